// File: rtl/imem_boot_loader.sv
// Streams a little-endian byte image (16-bit word-count header, then words) into
// instruction memory and holds the core in reset until the last word is written.
module imem_boot_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [23:0]         asm_q, asm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept;
  logic [CNT_W-1:0]    hdr_count;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready drops during the write-strobe cycle and whenever start is high.
  assign in_ready = ((state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA))
                    && !we_q && !start;
  assign accept    = in_valid && in_ready;
  assign hdr_count = CNT_W'({in_data, count_q[7:0]});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LEN0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      count_q    <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    count_d    = count_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    err_d      = err_q;

    case (state_q)
      S_LEN0: begin
        if (accept) begin
          count_d = CNT_W'(in_data);
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count == '0) begin
            state_d = S_WAIT;
          end else if (hdr_count > CAPACITY) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (byte_idx_q == 2'd3) begin
            wdata_d    = {in_data, asm_q};
            addr_d     = word_cnt_q[ADDR_W-1:0];
            we_d       = 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
            byte_idx_d = 2'd0;
            // word_cnt_q is the index of the word being written now
            if (CNT_W'(word_cnt_q) == count_q - CNT_W'(1)) state_d = S_WAIT;
          end else begin
            asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_WAIT: begin
        state_d    = S_DONE;
        core_rst_d = 1'b0;
        done_d     = 1'b1;
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_LEN0;
    endcase

    if (start) begin
      state_d    = S_LEN0;
      byte_idx_d = '0;
      word_cnt_d = '0;
      count_d    = '0;
      we_d       = 1'b0;
      core_rst_d = 1'b1;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule
